tmr_voter_scrub: RTL

Parametrised triple-modular-redundancy voter for the radiation-hardened datapath. It takes three replica copies of CHANNELS words of WIDTH bits each and produces a registered, bitwise-majority-voted result. For each replica it keeps a saturating disagreement counter and a persistence state machine that escalates repeated disagreement to a sticky fault flag and a one-shot resync request. It sits between the triplicated computation replicas (for example, the calculator replicas) and downstream consumers, and generalises the fixed 2×16-bit voter with fault tracking.

---
 rtl/tmr_pkg.sv | 12 +
 rtl/tmr_replica_monitor.sv | 92 +++++++++
 rtl/tmr_voter_scrub.sv | 103 ++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types and constants for the triple-modular-redundancy voter.
package tmr_pkg;

  localparam int NUM_REPLICAS = 3;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } replica_state_e;

endpackage

// File: rtl/tmr_replica_monitor.sv
// Per-replica persistence tracker: escalates consecutive blamed samples to a
// sticky fault with a one-shot resync pulse, and keeps a saturating blame count.
module tmr_replica_monitor
  import tmr_pkg::*;
#(
  parameter int PERSIST = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             blamed,
  input  logic             clear,
  output logic             fault,
  output logic             resync,
  output logic [CNT_W-1:0] count
);

  localparam int RUN_W = $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0] PERSIST_V = RUN_W'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  replica_state_e   state_r;
  logic [RUN_W-1:0] run_r;
  logic [CNT_W-1:0] count_r;
  logic             fault_r;
  logic             resync_r;

  // State, run length, blame counter and registered fault/resync outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= HEALTHY;
      run_r    <= {RUN_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      fault_r  <= 1'b0;
      resync_r <= 1'b0;
    end else begin
      resync_r <= 1'b0;
      if (clear) begin
        state_r <= HEALTHY;
        run_r   <= {RUN_W{1'b0}};
        count_r <= {CNT_W{1'b0}};
        fault_r <= 1'b0;
      end else if (valid) begin
        if (blamed && (count_r != CNT_MAX)) begin
          count_r <= count_r + CNT_W'(1);
        end
        case (state_r)
          HEALTHY: begin
            if (blamed) begin
              run_r <= RUN_W'(1);
              if (PERSIST_V == RUN_W'(1)) begin
                state_r  <= FAULTY;
                fault_r  <= 1'b1;
                resync_r <= 1'b1;
              end else begin
                state_r <= SUSPECT;
              end
            end
          end
          SUSPECT: begin
            if (blamed) begin
              run_r <= run_r + RUN_W'(1);
              if ((run_r + RUN_W'(1)) == PERSIST_V) begin
                state_r  <= FAULTY;
                fault_r  <= 1'b1;
                resync_r <= 1'b1;
              end
            end else begin
              state_r <= HEALTHY;
              run_r   <= {RUN_W{1'b0}};
            end
          end
          // A faulty replica stays faulty until cleared or reset.
          FAULTY: begin
            state_r <= FAULTY;
          end
          default: begin
            state_r <= HEALTHY;
            run_r   <= {RUN_W{1'b0}};
            fault_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fault  = fault_r;
  assign resync = resync_r;
  assign count  = count_r;

endmodule

// File: rtl/tmr_voter_scrub.sv
// Bitwise-majority voter over three replicas with per-replica fault tracking;
// all outputs are registered with one cycle of latency.
module tmr_voter_scrub
  import tmr_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int PERSIST  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [CHANNELS*WIDTH-1:0]   rep0_data,
  input  logic [CHANNELS*WIDTH-1:0]   rep1_data,
  input  logic [CHANNELS*WIDTH-1:0]   rep2_data,
  input  logic                        clear_faults,
  output logic                        out_valid,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic                        mismatch,
  output logic                        uncorrectable,
  output logic [2:0]                  replica_fault,
  output logic [2:0]                  resync_req,
  output logic [3*CNT_W-1:0]          err_count
);

  logic [CHANNELS*WIDTH-1:0] voted_s;
  logic [2:0]                blame_s;
  logic                      mismatch_s;
  logic                      uncorr_s;

  logic                      out_valid_r;
  logic [CHANNELS*WIDTH-1:0] out_data_r;
  logic                      mismatch_r;
  logic                      uncorr_r;

  logic [2:0]                fault_s;
  logic [2:0]                resync_s;
  logic [CNT_W-1:0]          count_s [NUM_REPLICAS];

  // Per-channel majority vote plus blame, mismatch and uncorrectable reduction.
  always_comb begin
    logic [WIDTH-1:0] a, b, c, v;
    voted_s    = {(CHANNELS*WIDTH){1'b0}};
    blame_s    = 3'b000;
    mismatch_s = 1'b0;
    uncorr_s   = 1'b0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      a = rep0_data[ch*WIDTH +: WIDTH];
      b = rep1_data[ch*WIDTH +: WIDTH];
      c = rep2_data[ch*WIDTH +: WIDTH];
      v = (a & b) | (a & c) | (b & c);
      voted_s[ch*WIDTH +: WIDTH] = v;
      blame_s[0] = blame_s[0] | (a != v);
      blame_s[1] = blame_s[1] | (b != v);
      blame_s[2] = blame_s[2] | (c != v);
      mismatch_s = mismatch_s | (a != b) | (a != c) | (b != c);
      uncorr_s   = uncorr_s | ((a != b) & (a != c) & (b != c));
    end
  end

  // Output registers; voted data holds between valid samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(CHANNELS*WIDTH){1'b0}};
      mismatch_r  <= 1'b0;
      uncorr_r    <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      mismatch_r  <= in_valid & mismatch_s;
      uncorr_r    <= in_valid & uncorr_s;
      if (in_valid) begin
        out_data_r <= voted_s;
      end
    end
  end

  for (genvar r = 0; r < NUM_REPLICAS; r++) begin : g_mon
    tmr_replica_monitor #(
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W)
    ) u_mon (
      .clk    (clk),
      .rst    (rst),
      .valid  (in_valid),
      .blamed (blame_s[r]),
      .clear  (clear_faults),
      .fault  (fault_s[r]),
      .resync (resync_s[r]),
      .count  (count_s[r])
    );
    assign err_count[r*CNT_W +: CNT_W] = count_s[r];
  end

  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign mismatch      = mismatch_r;
  assign uncorrectable = uncorr_r;
  assign replica_fault = fault_s;
  assign resync_req    = resync_s;

endmodule
